// File: rtl/menu_text_overlay.sv
// Menu text overlay: maps the pixel stream onto text ROM addresses and
// composites font ROM pixels over the background, with a typewriter reveal.
module menu_text_overlay #(
  parameter int          XPOS          = 64,
  parameter int          YPOS          = 128,
  parameter int          CHAR_W        = 8,
  parameter int          CHAR_H        = 16,
  parameter logic [11:0] TEXT_RGB      = 12'hFFF,
  parameter int          REVEAL_FRAMES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic        start,
  input  logic        reveal_en,
  output logic [7:0]  char_xy,
  output logic [3:0]  char_line,
  input  logic [7:0]  char_pixels,
  output logic        reveal_done,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);
  localparam int XB = $clog2(CHAR_W);
  localparam int YB = $clog2(CHAR_H);
  localparam int FW = (REVEAL_FRAMES > 1) ? $clog2(REVEAL_FRAMES) : 1;
  localparam int VW = 38;
  localparam logic [10:0] X_LO = 11'(XPOS);
  localparam logic [10:0] X_HI = 11'(XPOS + 128);
  localparam logic [10:0] Y_LO = 11'(YPOS);
  localparam logic [10:0] Y_HI = 11'(YPOS + 256);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REVEAL = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [8:0]    reveal_cnt_q, reveal_cnt_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;

  logic [7:0]    char_xy_q, char_xy_d;
  logic [3:0]    line1_q, line1_d;
  logic [3:0]    char_line_q, char_line_d;
  logic [XB-1:0] bit1_q, bit1_d;
  logic [XB-1:0] bit2_q, bit2_d;
  logic [XB-1:0] bit3_q, bit3_d;
  logic          in_box1_q, in_box1_d;
  logic          in_box2_q, in_box2_d;
  logic          in_box3_q, in_box3_d;
  logic          ren1_q, ren1_d;
  logic          vis2_q, vis2_d;
  logic          vis3_q, vis3_d;
  logic [VW-1:0] vid1_q, vid1_d;
  logic [VW-1:0] vid2_q, vid2_d;
  logic [VW-1:0] vid3_q, vid3_d;

  logic [6:0]    rel_x;
  logic [7:0]    rel_y;
  logic          in_box;
  logic          frame_tick;
  logic          visible;
  logic          pixel;
  logic [11:0]   rgb3;

  assign char_xy   = char_xy_q;
  assign char_line = char_line_q;
  assign {hcount_out, vcount_out, hsync_out, vsync_out,
          hblnk_out, vblnk_out, rgb3} = vid3_q;

  // Box-relative coordinates; the range test uses the raw counts so left of the box never wraps in
  always_comb begin
    rel_x      = 7'(hcount_in - X_LO);
    rel_y      = 8'(vcount_in - Y_LO);
    in_box     = (hcount_in >= X_LO) && (hcount_in < X_HI) &&
                 (vcount_in >= Y_LO) && (vcount_in < Y_HI);
    frame_tick = (hcount_in == '0) && (vcount_in == '0);
    visible    = ~ren1_q | (state_q == DONE) |
                 ({1'b0, char_xy_q} < reveal_cnt_q);
  end

  // Three-stage pixel pipeline matching text ROM then registered font ROM latency
  always_comb begin
    char_xy_d   = in_box ? {rel_y[YB +: 4], rel_x[XB +: 4]} : char_xy_q;
    line1_d     = rel_y[YB-1:0];
    bit1_d      = rel_x[XB-1:0];
    in_box1_d   = in_box;
    ren1_d      = reveal_en;
    char_line_d = line1_q;
    bit2_d      = bit1_q;
    in_box2_d   = in_box1_q;
    vis2_d      = visible;
    bit3_d      = bit2_q;
    in_box3_d   = in_box2_q;
    vis3_d      = vis2_q;
    vid1_d      = {hcount_in, vcount_in, hsync_in, vsync_in,
                   hblnk_in, vblnk_in, rgb_in};
    vid2_d      = vid1_q;
    vid3_d      = vid2_q;
  end

  // Reveal FSM next state; a start pulse always wins over a frame tick
  always_comb begin
    state_d      = state_q;
    reveal_cnt_d = reveal_cnt_q;
    frame_cnt_d  = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        reveal_cnt_d = '0;
        frame_cnt_d  = '0;
        if (start) state_d = REVEAL;
      end
      REVEAL: begin
        if (start) begin
          reveal_cnt_d = '0;
          frame_cnt_d  = '0;
        end else if (frame_tick) begin
          if (frame_cnt_q == FW'(REVEAL_FRAMES - 1)) begin
            frame_cnt_d  = '0;
            reveal_cnt_d = reveal_cnt_q + 9'd1;
            if (reveal_cnt_q == 9'd255) state_d = DONE;
          end else begin
            frame_cnt_d = frame_cnt_q + FW'(1);
          end
        end
      end
      DONE: begin
        if (start) begin
          state_d      = REVEAL;
          reveal_cnt_d = '0;
          frame_cnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: reveal status and the final glyph-over-background mux
  always_comb begin
    reveal_done = (state_q == DONE);
    pixel       = in_box3_q & ~hblnk_out & ~vblnk_out & vis3_q &
                  char_pixels[~bit3_q];
    rgb_out     = pixel ? TEXT_RGB : rgb3;
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      reveal_cnt_q <= '0;
      frame_cnt_q  <= '0;
      char_xy_q    <= '0;
      line1_q      <= '0;
      char_line_q  <= '0;
      bit1_q       <= '0;
      bit2_q       <= '0;
      bit3_q       <= '0;
      in_box1_q    <= 1'b0;
      in_box2_q    <= 1'b0;
      in_box3_q    <= 1'b0;
      ren1_q       <= 1'b0;
      vis2_q       <= 1'b0;
      vis3_q       <= 1'b0;
      vid1_q       <= '0;
      vid2_q       <= '0;
      vid3_q       <= '0;
    end else begin
      state_q      <= state_d;
      reveal_cnt_q <= reveal_cnt_d;
      frame_cnt_q  <= frame_cnt_d;
      char_xy_q    <= char_xy_d;
      line1_q      <= line1_d;
      char_line_q  <= char_line_d;
      bit1_q       <= bit1_d;
      bit2_q       <= bit2_d;
      bit3_q       <= bit3_d;
      in_box1_q    <= in_box1_d;
      in_box2_q    <= in_box2_d;
      in_box3_q    <= in_box3_d;
      ren1_q       <= ren1_d;
      vis2_q       <= vis2_d;
      vis3_q       <= vis3_d;
      vid1_q       <= vid1_d;
      vid2_q       <= vid2_d;
      vid3_q       <= vid3_d;
    end
  end
endmodule

// File: tb/tb_menu_text_overlay.sv
// Bench for menu_text_overlay: directed scenarios plus randomized
// stimulus checked against a frame-count model of the overlay.
module tb_menu_text_overlay;
  localparam int XPOS = 64;
  localparam int YPOS = 128;
  localparam int RF   = 2;
  localparam logic [11:0] TXT = 12'hFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic        start, reveal_en;
  logic [7:0]  char_xy;
  logic [3:0]  char_line;
  logic [7:0]  char_pixels;
  logic        reveal_done;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  menu_text_overlay dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .start(start), .reveal_en(reveal_en),
    .char_xy(char_xy), .char_line(char_line),
    .char_pixels(char_pixels), .reveal_done(reveal_done),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  typedef struct {
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic        inb;
    logic [2:0]  bi;
    logic [3:0]  line;
    logic [7:0]  xy;
    logic        vis;
  } rec_t;

  rec_t hist [3];
  rec_t zr;
  rec_t e3;
  logic [7:0]  m_xy;
  int          m_ticks;
  bit          m_started;
  logic [3:0]  e_line;
  logic [7:0]  e_xy;
  logic        e_done;
  logic [11:0] e_rgb;
  logic        ren_g;
  int checks = 0;
  int errors = 0;

  function automatic bit m_done();
    return m_started && (m_ticks >= 256 * RF);
  endfunction

  function automatic int m_cnt();
    int c;
    if (!m_started) return 0;
    c = m_ticks / RF;
    return (c > 256) ? 256 : c;
  endfunction

  // One pixel clock: latch expectations, drive inputs, advance the model
  task automatic cyc(input logic [10:0] hc, input logic [10:0] vc,
                     input logic hs, input logic vs,
                     input logic hb, input logic vb,
                     input logic [11:0] rgb, input logic st,
                     input logic ren, input logic r,
                     input logic [7:0] cp);
    rec_t n;
    logic px;
    int rx, ry;
    @(posedge clk); #1;
    e3     = hist[2];
    e_line = hist[1].line;
    e_xy   = hist[0].xy;
    e_done = m_done();
    hcount_in = hc; vcount_in = vc;
    hsync_in = hs; vsync_in = vs;
    hblnk_in = hb; vblnk_in = vb;
    rgb_in = rgb; start = st; reveal_en = ren;
    rst = r; char_pixels = cp;
    px = e3.inb & ~e3.hb & ~e3.vb & e3.vis & cp[7 - e3.bi];
    e_rgb = px ? TXT : e3.rgb;
    if (r) begin
      m_started = 0;
      m_ticks = 0;
    end else if (st) begin
      m_started = 1;
      m_ticks = 0;
    end else if (hc == 0 && vc == 0 && m_started && !m_done()) begin
      m_ticks++;
    end
    rx = int'(hc) - XPOS;
    ry = int'(vc) - YPOS;
    n.hc = hc; n.vc = vc; n.hs = hs; n.vs = vs;
    n.hb = hb; n.vb = vb; n.rgb = rgb;
    n.inb = (rx >= 0) && (rx < 128) && (ry >= 0) && (ry < 256);
    n.bi = 3'(rx & 7);
    n.line = 4'(ry & 15);
    if (n.inb) m_xy = {4'(ry / 16), 4'(rx / 8)};
    n.xy = m_xy;
    n.vis = !ren || m_done() || (int'(m_xy) < m_cnt());
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = n;
    if (r) begin
      m_xy = '0;
      for (int i = 0; i < 3; i++) hist[i] = zr;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic [7:0] cp);
    cyc(11'd1000, 11'd600, 1'b0, 1'b0, 1'b1, 1'b1,
        12'($urandom), 1'b0, ren_g, 1'b0, cp);
  endtask

  task automatic tick();
    cyc(11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b1,
        12'h000, 1'b0, ren_g, 1'b0, 8'h00);
  endtask

  task automatic pulse_start(input logic [10:0] hc, input logic [10:0] vc);
    cyc(hc, vc, 1'b0, 1'b0, 1'b1, 1'b1,
        12'h000, 1'b1, ren_g, 1'b0, 8'h00);
  endtask

  // Present one pixel and stop on the cycle its composite appears
  task automatic probe(input int hc, input int vc, input logic hb,
                       input logic [7:0] cp, input logic [11:0] rgb);
    cyc(11'(hc), 11'(vc), 1'b0, 1'b0, hb, 1'b0,
        rgb, 1'b0, ren_g, 1'b0, 8'h00);
    idle(8'h00);
    idle(8'h00);
    idle(cp);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++)
      cyc(11'($urandom), 11'($urandom), 1'($urandom), 1'($urandom),
          1'($urandom), 1'($urandom), 12'($urandom), 1'($urandom),
          1'($urandom), 1'b1, 8'($urandom));
    checks++; if (rgb_out !== 12'h0) begin errors++; $display("FAIL reset_rgb got=%h exp=0", rgb_out); end
    checks++; if (hcount_out !== 11'h0) begin errors++; $display("FAIL reset_hcount got=%h exp=0", hcount_out); end
    checks++; if (vcount_out !== 11'h0) begin errors++; $display("FAIL reset_vcount got=%h exp=0", vcount_out); end
    checks++; if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== 4'h0) begin
      errors++; $display("FAIL reset_sync got=%b exp=0000", {hsync_out, vsync_out, hblnk_out, vblnk_out}); end
    checks++; if (char_xy !== 8'h0) begin errors++; $display("FAIL reset_char_xy got=%h exp=0", char_xy); end
    checks++; if (char_line !== 4'h0) begin errors++; $display("FAIL reset_char_line got=%h exp=0", char_line); end
    checks++; if (reveal_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", reveal_done); end
    cyc(11'd1000, 11'd600, 1'b0, 1'b0, 1'b1, 1'b1, 12'h0, 1'b0, 1'b0, 1'b0, 8'h0);
  endtask

  task automatic test_latency();
    ren_g = 1'b0;
    cyc(11'(XPOS + 9), 11'(YPOS + 35), 1'b1, 1'b0, 1'b0, 1'b0,
        12'h5A3, 1'b0, ren_g, 1'b0, 8'h00);
    idle(8'h00);
    checks++; if (char_xy !== 8'h21) begin errors++; $display("FAIL lat_char_xy got=%h exp=21", char_xy); end
    idle(8'h00);
    checks++; if (char_line !== 4'd3) begin errors++; $display("FAIL lat_char_line got=%h exp=3", char_line); end
    idle(8'h00);
    checks++; if (hsync_out !== 1'b1) begin errors++; $display("FAIL lat_hsync got=%b exp=1", hsync_out); end
    checks++; if (hcount_out !== 11'(XPOS + 9)) begin errors++; $display("FAIL lat_hcount got=%0d exp=%0d", hcount_out, XPOS + 9); end
    checks++; if (vcount_out !== 11'(YPOS + 35)) begin errors++; $display("FAIL lat_vcount got=%0d exp=%0d", vcount_out, YPOS + 35); end
    checks++; if (rgb_out !== 12'h5A3) begin errors++; $display("FAIL lat_rgb got=%h exp=5A3", rgb_out); end
    idle(8'h00);
    checks++; if (hsync_out !== 1'b0) begin errors++; $display("FAIL lat_hsync_after got=%b exp=0", hsync_out); end
  endtask

  task automatic test_overlay();
    logic [11:0] want, bg;
    logic [7:0] cp;
    int hc, vc, b;
    ren_g = 1'b0;
    probe(XPOS + 8, YPOS + 20, 1'b0, 8'h80, 12'h123);
    checks++; if (rgb_out !== 12'hFFF) begin errors++; $display("FAIL ovl_bit0 got=%h exp=FFF", rgb_out); end
    probe(XPOS + 9, YPOS + 20, 1'b0, 8'h80, 12'h123);
    checks++; if (rgb_out !== 12'h123) begin errors++; $display("FAIL ovl_bit1 got=%h exp=123", rgb_out); end
    probe(XPOS + 9, YPOS + 20, 1'b0, 8'h40, 12'h123);
    checks++; if (rgb_out !== 12'hFFF) begin errors++; $display("FAIL ovl_bit1_set got=%h exp=FFF", rgb_out); end
    for (int i = 0; i < 24; i++) begin
      hc = XPOS + int'($urandom_range(0, 127));
      vc = YPOS + int'($urandom_range(0, 255));
      cp = 8'($urandom);
      bg = 12'($urandom);
      b  = (hc - XPOS) % 8;
      want = cp[7 - b] ? 12'hFFF : bg;
      probe(hc, vc, 1'b0, cp, bg);
      checks++; if (rgb_out !== want) begin
        errors++; $display("FAIL ovl_rand hc=%0d cp=%h got=%h exp=%h", hc, cp, rgb_out, want); end
    end
  endtask

  task automatic test_edges();
    ren_g = 1'b0;
    probe(XPOS - 1, YPOS + 4, 1'b0, 8'hFF, 12'h0C3);
    checks++; if (rgb_out !== 12'h0C3) begin errors++; $display("FAIL edge_left got=%h exp=0C3", rgb_out); end
    probe(XPOS + 128, YPOS + 4, 1'b0, 8'hFF, 12'h0C3);
    checks++; if (rgb_out !== 12'h0C3) begin errors++; $display("FAIL edge_right got=%h exp=0C3", rgb_out); end
    probe(XPOS, YPOS + 255, 1'b0, 8'h80, 12'h0C3);
    checks++; if (rgb_out !== 12'hFFF) begin errors++; $display("FAIL edge_bottom_in got=%h exp=FFF", rgb_out); end
    probe(XPOS + 127, YPOS, 1'b0, 8'h01, 12'h0C3);
    checks++; if (rgb_out !== 12'hFFF) begin errors++; $display("FAIL edge_right_in got=%h exp=FFF", rgb_out); end
    probe(XPOS, YPOS + 256, 1'b0, 8'hFF, 12'h0C3);
    checks++; if (rgb_out !== 12'h0C3) begin errors++; $display("FAIL edge_below got=%h exp=0C3", rgb_out); end
    probe(XPOS, YPOS - 1, 1'b0, 8'hFF, 12'h0C3);
    checks++; if (rgb_out !== 12'h0C3) begin errors++; $display("FAIL edge_above got=%h exp=0C3", rgb_out); end
    probe(XPOS + 20, YPOS + 20, 1'b1, 8'hFF, 12'h0C3);
    checks++; if (rgb_out !== 12'h0C3) begin errors++; $display("FAIL edge_hblnk got=%h exp=0C3", rgb_out); end
  endtask

  task automatic test_reveal();
    ren_g = 1'b1;
    pulse_start(11'd1000, 11'd600);
    probe(XPOS, YPOS, 1'b0, 8'hFF, 12'h0AB);
    checks++; if (rgb_out !== 12'h0AB) begin errors++; $display("FAIL rev_c0_start got=%h exp=0AB", rgb_out); end
    for (int i = 0; i < 4; i++) tick();
    probe(XPOS, YPOS, 1'b0, 8'hFF, 12'h0AB);
    checks++; if (rgb_out !== 12'hFFF) begin errors++; $display("FAIL rev_c0 got=%h exp=FFF", rgb_out); end
    probe(XPOS + 8, YPOS, 1'b0, 8'hFF, 12'h0AB);
    checks++; if (rgb_out !== 12'hFFF) begin errors++; $display("FAIL rev_c1 got=%h exp=FFF", rgb_out); end
    probe(XPOS + 16, YPOS, 1'b0, 8'hFF, 12'h0AB);
    checks++; if (rgb_out !== 12'h0AB) begin errors++; $display("FAIL rev_c2 got=%h exp=0AB", rgb_out); end
    probe(XPOS, YPOS + 16, 1'b0, 8'hFF, 12'h0AB);
    checks++; if (rgb_out !== 12'h0AB) begin errors++; $display("FAIL rev_c16 got=%h exp=0AB", rgb_out); end
    for (int i = 0; i < 507; i++) tick();
    idle(8'h00);
    checks++; if (reveal_done !== 1'b0) begin errors++; $display("FAIL rev_done_511 got=%b exp=0", reveal_done); end
    probe(XPOS + 120, YPOS + 240, 1'b0, 8'hFF, 12'h0AB);
    checks++; if (rgb_out !== 12'h0AB) begin errors++; $display("FAIL rev_c255_pre got=%h exp=0AB", rgb_out); end
    tick();
    idle(8'h00);
    checks++; if (reveal_done !== 1'b1) begin errors++; $display("FAIL rev_done_512 got=%b exp=1", reveal_done); end
    probe(XPOS + 120, YPOS + 240, 1'b0, 8'hFF, 12'h0AB);
    checks++; if (rgb_out !== 12'hFFF) begin errors++; $display("FAIL rev_c255_done got=%h exp=FFF", rgb_out); end
  endtask

  task automatic test_restart();
    ren_g = 1'b1;
    pulse_start(11'd1000, 11'd600);
    for (int i = 0; i < 20; i++) tick();
    probe(XPOS + 72, YPOS, 1'b0, 8'hFF, 12'h321);
    checks++; if (rgb_out !== 12'hFFF) begin errors++; $display("FAIL rst_c9 got=%h exp=FFF", rgb_out); end
    probe(XPOS + 80, YPOS, 1'b0, 8'hFF, 12'h321);
    checks++; if (rgb_out !== 12'h321) begin errors++; $display("FAIL rst_c10 got=%h exp=321", rgb_out); end
    pulse_start(11'd0, 11'd0);
    idle(8'h00);
    checks++; if (reveal_done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", reveal_done); end
    probe(XPOS, YPOS, 1'b0, 8'hFF, 12'h321);
    checks++; if (rgb_out !== 12'h321) begin errors++; $display("FAIL rst_c0_cleared got=%h exp=321", rgb_out); end
    tick();
    tick();
    probe(XPOS, YPOS, 1'b0, 8'hFF, 12'h321);
    checks++; if (rgb_out !== 12'hFFF) begin errors++; $display("FAIL rst_c0_again got=%h exp=FFF", rgb_out); end
    probe(XPOS + 8, YPOS, 1'b0, 8'hFF, 12'h321);
    checks++; if (rgb_out !== 12'h321) begin errors++; $display("FAIL rst_c1_again got=%h exp=321", rgb_out); end
  endtask

  task automatic test_random();
    logic [10:0] hc, vc;
    int r;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 3) begin
        hc = 11'd0; vc = 11'd0;
      end else begin
        hc = 11'($urandom_range(XPOS - 8, XPOS + 135));
        vc = 11'($urandom_range(YPOS - 8, YPOS + 263));
      end
      if ($urandom_range(0, 199) == 0) ren_g = ~ren_g;
      cyc(hc, vc, 1'($urandom), 1'($urandom),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
          12'($urandom), ($urandom_range(0, 399) == 0), ren_g,
          ($urandom_range(0, 299) == 0), 8'($urandom));
      checks++; if (rgb_out !== e_rgb) begin errors++; $display("FAIL rnd_rgb i=%0d got=%h exp=%h", i, rgb_out, e_rgb); end
      checks++; if (hcount_out !== e3.hc) begin errors++; $display("FAIL rnd_hcount i=%0d got=%h exp=%h", i, hcount_out, e3.hc); end
      checks++; if (vcount_out !== e3.vc) begin errors++; $display("FAIL rnd_vcount i=%0d got=%h exp=%h", i, vcount_out, e3.vc); end
      checks++; if ({hsync_out, vsync_out, hblnk_out, vblnk_out} !== {e3.hs, e3.vs, e3.hb, e3.vb}) begin
        errors++; $display("FAIL rnd_sync i=%0d got=%b exp=%b", i,
          {hsync_out, vsync_out, hblnk_out, vblnk_out}, {e3.hs, e3.vs, e3.hb, e3.vb}); end
      checks++; if (char_xy !== e_xy) begin errors++; $display("FAIL rnd_char_xy i=%0d got=%h exp=%h", i, char_xy, e_xy); end
      checks++; if (char_line !== e_line) begin errors++; $display("FAIL rnd_char_line i=%0d got=%h exp=%h", i, char_line, e_line); end
      checks++; if (reveal_done !== e_done) begin errors++; $display("FAIL rnd_done i=%0d got=%b exp=%b", i, reveal_done, e_done); end
    end
  endtask

  initial begin
    zr = '{hc: '0, vc: '0, hs: 0, vs: 0, hb: 0, vb: 0, rgb: '0,
           inb: 0, bi: '0, line: '0, xy: '0, vis: 0};
    for (int i = 0; i < 3; i++) hist[i] = zr;
    m_xy = '0; m_ticks = 0; m_started = 0; ren_g = 1'b0;
    rst = 1'b1; hcount_in = '0; vcount_in = '0;
    hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
    rgb_in = '0; start = 0; reveal_en = 0; char_pixels = '0;
    test_reset();
    test_latency();
    test_overlay();
    test_edges();
    test_reveal();
    test_restart();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
